// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the memory-slave FSM state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } ahb_state_e;

endpackage

// File: rtl/ahb_byte_lane_dec.sv
// Byte-lane strobe and misalignment decode from transfer size and low address bits.
module ahb_byte_lane_dec #(
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned NB         = DATA_WIDTH / 8,
  localparam int unsigned LANE_BITS  = $clog2(NB)
) (
  input  logic [2:0]           size,
  input  logic [LANE_BITS-1:0] addr_lo,
  output logic [NB-1:0]        strb,
  output logic                 misalign
);

  int unsigned nbytes;
  int unsigned lo;

  // Lanes lo .. lo+nbytes-1 are selected; lane n is HWDATA[8n+7:8n].
  always_comb begin
    nbytes   = 32'd1 << size;
    lo       = 32'(addr_lo);
    misalign = (lo & (nbytes - 32'd1)) != 32'd0;
    strb     = '0;
    for (int unsigned n = 0; n < NB; n++) begin
      strb[n] = (n >= lo) && (n < lo + nbytes);
    end
  end

endmodule

// File: rtl/ahb_mem_slave_ws.sv
// AHB SRAM slave with byte-lane writes, compile-time wait states and two-cycle ERROR.
// Optional: define AHB_SLV_SEQ_NOWAIT_EN so SEQ beats following a DATA phase skip the wait states.
module ahb_mem_slave_ws
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP
);

  localparam int unsigned NB        = DATA_WIDTH / 8;
  localparam int unsigned LANE_BITS = $clog2(NB);
  localparam int unsigned WIDX_W    = ADDR_WIDTH - LANE_BITS;
  localparam int unsigned IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned CNT_W     = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int unsigned WS_LAST   = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  ahb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  word_q;
  logic              wr_q;
  logic [NB-1:0]     strb_q;

  logic [WIDX_W-1:0] widx_c;
  logic [NB-1:0]     strb_c;
  logic              misalign_c;
  logic              oob_c;
  logic              oversize_c;
  logic              accept_c;
  logic              xfer_err_c;
  logic              seq_skip_c;
  logic              capture_c;
  logic              we_c;
  logic              unused_ok;

  ahb_byte_lane_dec #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_dec (
    .size     (HSIZE),
    .addr_lo  (HADDR[LANE_BITS-1:0]),
    .strb     (strb_c),
    .misalign (misalign_c)
  );

  // Address-phase classification
  assign widx_c     = HADDR[ADDR_WIDTH-1:LANE_BITS];
  assign oob_c      = widx_c >= WIDX_W'(MEM_DEPTH);
  assign oversize_c = HSIZE > 3'(LANE_BITS);
  assign xfer_err_c = oob_c || misalign_c || oversize_c;
  assign accept_c   = HSEL && HTRANS[1] && HREADY;

`ifdef AHB_SLV_SEQ_NOWAIT_EN
  assign seq_skip_c = (state_q == ST_DATA) && (HTRANS == HTRANS_SEQ);
`else
  assign seq_skip_c = 1'b0;
`endif

  assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

  // Next state, capture/commit enables and bus responses
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture_c = 1'b0;
    we_c      = 1'b0;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = '0;
    case (state_q)
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (cnt_q == CNT_W'(WS_LAST)) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      default: begin
        // IDLE, DATA and ERR2 all close with HREADYOUT high and may take a pipelined address
        if (state_q == ST_ERR2) begin
          HRESP = HRESP_ERROR;
        end
        if (state_q == ST_DATA) begin
          we_c = wr_q;
          if (!wr_q) begin
            HRDATA = mem[word_q];
          end
        end
        state_d = ST_IDLE;
        if (accept_c) begin
          capture_c = 1'b1;
          if (xfer_err_c) begin
            state_d = ST_ERR1;
          end else if ((WAIT_STATES == 0) || seq_skip_c) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      wr_q    <= 1'b0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture_c) begin
        word_q <= widx_c[IDX_W-1:0];
        wr_q   <= HWRITE;
        strb_q <= strb_c;
      end
    end
  end

  // Write data is taken at the edge closing the DATA phase
  always_ff @(posedge HCLK) begin
    if (we_c) begin
      for (int unsigned n = 0; n < NB; n++) begin
        if (strb_q[n]) begin
          mem[word_q][8*n +: 8] <= HWDATA[8*n +: 8];
        end
      end
    end
  end

endmodule
